// File: rtl/wave_meas_pkg.sv
// Shared types and widths for the wave measurement sequencer and its divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: the sequencer state enum and the datapath widths.
package wave_meas_pkg;

  localparam int PERIOD_W  = 32;  // analyzer period count / frequency width
  localparam int AMP_W     = 12;  // analyzer amplitude width
  localparam int DIV_STEPS = 32;  // one quotient bit per cycle

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_STABLE,
    DIVIDE,
    ACCUM,
    PRESENT
  } state_e;

endpackage

// File: rtl/seq_divider_u32.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Latency: DIV_STEPS cycles after i_start; o_done pulses during the final step,
//          and o_quotient holds the final truncated quotient from the next cycle on.
// Backpressure: none; i_start restarts the divide unconditionally.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           load dividend/divisor and begin
//   i_dividend        numerator
//   i_divisor         denominator (caller guarantees nonzero)
//   o_busy            a divide is in progress
//   o_done            one-cycle pulse on the last step
//   o_quotient        quotient register (valid after o_done)
module seq_divider_u32
  import wave_meas_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [PERIOD_W-1:0] i_dividend,
  input  logic [PERIOD_W-1:0] i_divisor,
  output logic                o_busy,
  output logic                o_done,
  output logic [PERIOD_W-1:0] o_quotient
);

  localparam int STEP_W = $clog2(DIV_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_STEPS - 1);

  logic                r_busy;
  logic [STEP_W-1:0]   r_step;
  logic [PERIOD_W-1:0] r_rem;
  logic [PERIOD_W-1:0] r_quo;   // shifts dividend bits out the top, quotient bits in the bottom
  logic [PERIOD_W-1:0] r_div;

  logic [PERIOD_W:0]   w_shift;
  logic                w_ge;
  logic [PERIOD_W-1:0] w_diff;
  logic [PERIOD_W-1:0] w_rem_next;
  logic [PERIOD_W-1:0] w_quo_next;

  // The shifted remainder needs one extra bit; when it is >= divisor the
  // difference is below 2^32, so a 32-bit subtraction is exact.
  assign w_shift    = {r_rem, r_quo[PERIOD_W-1]};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_diff     = w_shift[PERIOD_W-1:0] - r_div;
  assign w_rem_next = w_ge ? w_diff : w_shift[PERIOD_W-1:0];
  assign w_quo_next = {r_quo[PERIOD_W-2:0], w_ge};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_step <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_step <= '0;
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_div  <= i_divisor;
    end else if (r_busy) begin
      r_rem  <= w_rem_next;
      r_quo  <= w_quo_next;
      r_step <= r_step + STEP_W'(1);
      if (r_step == LAST_STEP) r_busy <= 1'b0;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_step == LAST_STEP);
  assign o_quotient = r_quo;

endmodule

// File: rtl/wave_meas_sequencer.sv
// Clears the wave analyzer, waits for a frozen period, converts it to Hz and averages 2^AVG_LOG2 samples.
// Latency: per sample 1 (CLEAR) + measurement + STABLE_CYC + 32 (divide) + 1 (accumulate) cycles.
// Backpressure: result held in PRESENT until o_meas_valid && i_meas_ready; no new run starts until then.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_en                 permits a new averaging run from IDLE (sampled again on result acceptance)
//   i_period_in          analyzer period count (cycles per signal period)
//   i_amp_in             analyzer peak-to-peak amplitude
//   o_ana_clr            one-cycle analyzer restart pulse
//   o_freq_hz, o_amp_out averaged result
//   o_err                result comes from a timed-out run
//   o_meas_valid         result available; i_meas_ready accepts it
//   o_busy               sequencer not idle
module wave_meas_sequencer
  import wave_meas_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned STABLE_CYC  = 1024,
  parameter int unsigned TIMEOUT_CYC = 16_777_216,
  parameter int unsigned AVG_LOG2    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [PERIOD_W-1:0] i_period_in,
  input  logic [AMP_W-1:0]    i_amp_in,
  output logic                o_ana_clr,
  output logic [PERIOD_W-1:0] o_freq_hz,
  output logic [AMP_W-1:0]    o_amp_out,
  output logic                o_err,
  output logic                o_meas_valid,
  input  logic                i_meas_ready,
  output logic                o_busy
);

  localparam int STB_W  = (STABLE_CYC > 1)  ? $clog2(STABLE_CYC)  : 1;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int FACC_W = PERIOD_W + AVG_LOG2;
  localparam int AACC_W = AMP_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;

  localparam logic [STB_W-1:0]    STABLE_LAST  = STB_W'(STABLE_CYC - 1);
  localparam logic [TMO_W-1:0]    TIMEOUT_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST     = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [PERIOD_W-1:0] DIVIDEND     = PERIOD_W'(CLK_HZ);

  state_e r_state;
  state_e w_next;

  logic [PERIOD_W-1:0] r_prev;
  logic [STB_W-1:0]    r_stable;
  logic [TMO_W-1:0]    r_tmo;
  logic [AMP_W-1:0]    r_amp_lat;
  logic [FACC_W-1:0]   r_freq_acc;
  logic [AACC_W-1:0]   r_amp_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [PERIOD_W-1:0] r_freq;
  logic [AMP_W-1:0]    r_amp;
  logic                r_err;

  logic                w_same;
  logic                w_stable_hit;
  logic                w_tmo_hit;
  logic                w_last;
  logic                w_accept;
  logic                w_div_start;
  logic                w_div_busy;
  logic                w_div_done;
  logic [PERIOD_W-1:0] w_quotient;
  logic [FACC_W-1:0]   w_freq_sum;
  logic [AACC_W-1:0]   w_amp_sum;
  logic [PERIOD_W-1:0] w_freq_avg;
  logic [AMP_W-1:0]    w_amp_avg;

  // A zero period means the analyzer has not produced a count yet, so it
  // never counts as stable; that also keeps the divisor nonzero.
  assign w_same       = (i_period_in != '0) && (i_period_in == r_prev);
  assign w_stable_hit = w_same && (r_stable == STABLE_LAST);
  assign w_tmo_hit    = (r_tmo == TIMEOUT_LAST);
  assign w_last       = (r_cnt == CNT_LAST);
  assign w_accept     = (r_state == PRESENT) && i_meas_ready;

  assign w_freq_sum = r_freq_acc + FACC_W'(w_quotient);
  assign w_amp_sum  = r_amp_acc + AACC_W'(r_amp_lat);
  assign w_freq_avg = PERIOD_W'(w_freq_sum >> AVG_LOG2);
  assign w_amp_avg  = AMP_W'(w_amp_sum >> AVG_LOG2);

  // The divider itself latches the frozen period as its divisor in the
  // capture cycle, so DIVIDE lasts exactly DIV_STEPS cycles.
  seq_divider_u32 u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_div_start),
    .i_dividend (DIVIDEND),
    .i_divisor  (i_period_in),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quotient)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_div_start = 1'b0;
    o_ana_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en) w_next = CLEAR;
      end
      CLEAR: begin
        o_ana_clr = 1'b1;
        w_next    = WAIT_STABLE;
      end
      WAIT_STABLE: begin
        // Stable has priority over a simultaneous timeout.
        if (w_stable_hit) begin
          w_div_start = 1'b1;
          w_next      = DIVIDE;
        end else if (w_tmo_hit) begin
          w_next = PRESENT;
        end
      end
      DIVIDE: begin
        if (w_div_done) w_next = ACCUM;
      end
      ACCUM: begin
        w_next = w_last ? PRESENT : CLEAR;
      end
      PRESENT: begin
        if (w_accept) w_next = i_en ? CLEAR : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev     <= '0;
      r_stable   <= '0;
      r_tmo      <= '0;
      r_amp_lat  <= '0;
      r_freq_acc <= '0;
      r_amp_acc  <= '0;
      r_cnt      <= '0;
      r_freq     <= '0;
      r_amp      <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_prev   <= '0;
          r_stable <= '0;
          r_tmo    <= '0;
        end
        WAIT_STABLE: begin
          r_prev   <= i_period_in;
          r_stable <= w_same ? r_stable + STB_W'(1) : '0;
          r_tmo    <= r_tmo + TMO_W'(1);
          if (w_stable_hit) begin
            r_amp_lat <= i_amp_in;
          end else if (w_tmo_hit) begin
            // Aborted run: report an error result and drop partial sums.
            r_freq     <= '0;
            r_amp      <= '0;
            r_err      <= 1'b1;
            r_freq_acc <= '0;
            r_amp_acc  <= '0;
            r_cnt      <= '0;
          end
        end
        ACCUM: begin
          r_freq_acc <= w_freq_sum;
          r_amp_acc  <= w_amp_sum;
          r_cnt      <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_freq <= w_freq_avg;
            r_amp  <= w_amp_avg;
            r_err  <= 1'b0;
          end
        end
        PRESENT: begin
          if (w_accept) begin
            r_freq_acc <= '0;
            r_amp_acc  <= '0;
            r_cnt      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_freq_hz    = r_freq;
  assign o_amp_out    = r_amp;
  assign o_err        = r_err;
  assign o_meas_valid = (r_state == PRESENT);
  assign o_busy       = (r_state != IDLE) || w_div_busy;

endmodule

// File: tb/tb_wave_meas_sequencer.sv
// Scoreboard bench for wave_meas_sequencer: two instances (no averaging / 4-sample averaging).
module tb_wave_meas_sequencer;

  typedef struct {
    logic [31:0] f;
    logic [11:0] a;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];

  // DUT0: no averaging, short timeout
  logic        rst0 = 1'b1, en0 = 1'b0, rdy0 = 1'b0;
  logic [31:0] per0 = '0;
  logic [11:0] amp0 = '0;
  logic        clr0, err0, vld0, busy0;
  logic [31:0] freq0;
  logic [11:0] ampo0;

  // DUT1: 4-sample averaging
  logic        rst1 = 1'b1, en1 = 1'b0, rdy1 = 1'b0;
  logic [31:0] per1 = '0;
  logic [11:0] amp1 = '0;
  logic        clr1, err1, vld1, busy1;
  logic [31:0] freq1;
  logic [11:0] ampo1;

  wave_meas_sequencer #(.CLK_HZ(50_000_000), .STABLE_CYC(1024), .TIMEOUT_CYC(5000), .AVG_LOG2(0)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_en(en0), .i_period_in(per0), .i_amp_in(amp0),
    .o_ana_clr(clr0), .o_freq_hz(freq0), .o_amp_out(ampo0), .o_err(err0),
    .o_meas_valid(vld0), .i_meas_ready(rdy0), .o_busy(busy0));

  wave_meas_sequencer #(.CLK_HZ(50_000_000), .STABLE_CYC(1024), .TIMEOUT_CYC(5000), .AVG_LOG2(2)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_en(en1), .i_period_in(per1), .i_amp_in(amp1),
    .o_ana_clr(clr1), .o_freq_hz(freq1), .o_amp_out(ampo1), .o_err(err1),
    .o_meas_valid(vld1), .i_meas_ready(rdy1), .o_busy(busy1));

  function automatic void chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Monitors: pop and compare on every accepted result.
  always @(negedge clk) begin
    exp_t x;
    if (vld0 && rdy0) begin
      if (q0.size() == 0) chk("dut0 unexpected result", q0.size(), 1);
      else begin
        x = q0.pop_front();
        chk("dut0 freq_hz", freq0, x.f);
        chk("dut0 amp_out", ampo0, x.a);
        chk("dut0 err", err0, x.e);
      end
    end
    if (vld1 && rdy1) begin
      if (q1.size() == 0) chk("dut1 unexpected result", q1.size(), 1);
      else begin
        x = q1.pop_front();
        chk("dut1 freq_hz", freq1, x.f);
        chk("dut1 amp_out", ampo1, x.a);
        chk("dut1 err", err1, x.e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clr0(output int c);
    int n = 0;
    step();
    while (!clr0 && n < 3000) begin step(); n++; end
    if (!clr0) chk("dut0 ana_clr timeout", 0, 1);
    c = cyc;
  endtask

  task automatic wait_vld0(input int bound, output int c);
    int n = 0;
    while (!vld0 && n < bound) begin step(); n++; end
    if (!vld0) chk("dut0 meas_valid timeout", 0, 1);
    c = cyc;
  endtask

  int c, v, bad, nclr, ph, n;
  int pers[4] = '{50000, 50000, 25000, 25000};
  int amps[4] = '{800, 800, 400, 402};

  initial begin
    repeat (3) step();
    rst0 = 1'b0; rst1 = 1'b0;
    step();
    chk("reset freq_hz", freq0, 0);
    chk("reset amp_out", ampo0, 0);
    chk("reset err", err0, 0);
    chk("reset meas_valid", vld0, 0);
    chk("reset busy", busy0, 0);
    chk("reset ana_clr", clr0, 0);

    // T1: ramp then freeze at 50000 / 800 -> 1000 Hz
    q0.push_back('{f: 32'd1000, a: 12'd800, e: 1'b0});
    per0 = 7; amp0 = 800; en0 = 1'b1;
    wait_clr0(c);
    en0 = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); per0 = 10000 + 7000 * i; end
    step(); per0 = 50000;
    wait_vld0(3000, v);
    chk("t1 latency", v - c, 1064);
    rdy0 = 1'b1;
    step(); rdy0 = 1'b0;
    chk("t1 valid drops", vld0, 0);
    chk("t1 idle after accept", busy0, 0);

    // T2: period 3 -> truncated quotient, then hold with ready low
    q0.push_back('{f: 32'd16666666, a: 12'd4095, e: 1'b0});
    per0 = 3; amp0 = 4095; en0 = 1'b1;
    wait_clr0(c);
    wait_vld0(3000, v);
    chk("t2 latency", v - c, 1059);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!vld0 || freq0 != 32'd16666666 || ampo0 != 12'd4095 || err0) bad++;
    end
    chk("hold cycles disturbed", bad, 0);
    rdy0 = 1'b1;
    step(); rdy0 = 1'b0;
    chk("t2 valid drops", vld0, 0);
    chk("t2 clear follows accept", clr0, 1);
    c = cyc;

    // Reset during DIVIDE cycle 10 of the next run
    while (cyc < c + 1035) step();
    chk("pre-reset busy", busy0, 1);
    chk("pre-reset freq held", freq0, 16666666);
    rst0 = 1'b1;
    step(); rst0 = 1'b0;
    chk("mid-divide reset freq_hz", freq0, 0);
    chk("mid-divide reset amp_out", ampo0, 0);
    chk("mid-divide reset valid", vld0, 0);
    chk("mid-divide reset busy", busy0, 0);
    chk("mid-divide reset ana_clr", clr0, 0);
    step();
    chk("ana_clr second cycle after reset", clr0, 1);
    c = cyc;

    // T3: period stuck at 0 -> timeout result; en dropped mid-run
    q0.push_back('{f: 32'd0, a: 12'd0, e: 1'b1});
    per0 = 0;
    repeat (10) step();
    en0 = 1'b0;
    wait_vld0(6000, v);
    chk("timeout latency", v - c, 5001);
    rdy0 = 1'b1;
    step(); rdy0 = 1'b0;
    chk("t3 valid drops", vld0, 0);
    chk("t3 idle after accept", busy0, 0);
    chk("t3 err held after accept", err0, 1);
    step();
    chk("t3 no clear when en low", clr0, 0);

    // DUT1: four averaged samples, ready held high throughout
    q1.push_back('{f: 32'd1500, a: 12'd600, e: 1'b0});
    rdy1 = 1'b1; en1 = 1'b1;
    nclr = 0; ph = 3; n = 0;
    step();
    while (!vld1 && n < 8000) begin
      if (clr1) begin
        nclr++; en1 = 1'b0; ph = 1; per1 = 100;
        if (nclr <= 4) amp1 = 12'(amps[nclr-1]);
      end else if (ph < 3) begin
        per1 = 100 + ph; ph++;
      end else if (nclr >= 1 && nclr <= 4) begin
        per1 = pers[nclr-1];
      end
      step(); n++;
    end
    if (!vld1) chk("dut1 meas_valid timeout", 0, 1);
    step();
    chk("dut1 ana_clr count", nclr, 4);
    chk("dut1 valid one cycle", vld1, 0);
    chk("dut1 idle after accept", busy1, 0);

    repeat (3) step();
    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wave_meas_sequencer.md
Name: wave_meas_sequencer

Overview:
- Sits directly downstream of the wave analyzer stage. Consumes its free-running period count (clock cycles per signal period) and peak-to-peak amplitude.
- The analyzer is one-shot per clear. This block therefore clears it, waits for the period count to freeze, and captures both values.
- It converts period to frequency in Hz with an iterative divider and averages 2^AVG_LOG2 measurements.
- It presents the result to the display/control logic over a valid/ready handshake.

Parameters:
- CLK_HZ, 50_000_000, clock frequency; dividend for the Hz conversion.
- STABLE_CYC, 1024, consecutive unchanged, nonzero period cycles that mark a finished measurement.
- TIMEOUT_CYC, 16_777_216, maximum cycles allowed in WAIT_STABLE before abort.
- AVG_LOG2, 2, log2 of the number of averaged measurements; legal range 0..4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  allows a new averaging run to start from IDLE
- period_in  in  32  analyzer period count
- amp_in  in  12  analyzer peak-to-peak amplitude
- ana_clr  out  1  one-cycle high pulse that restarts the analyzer
- freq_hz  out  32  averaged frequency in Hz
- amp_out  out  12  averaged amplitude
- err  out  1  the presented result is from an aborted (timed-out) run
- meas_valid  out  1  result available
- meas_ready  in  1  consumer accepts the result
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: on rst high at a clock edge, all outputs and state are 0. FSM goes to IDLE. Counters and accumulators clear. Reset asserted mid-run (including mid-divide) aborts the run with no result presented.
- IDLE: if en=1, go to CLEAR next cycle.
- CLEAR: ana_clr=1 for exactly this one cycle. Zero the stable and timeout counters. Go to WAIT_STABLE.
- WAIT_STABLE: register period_in each cycle as prev.
  - The stable counter increments when period_in!=0 and period_in==prev; otherwise it resets to 0.
  - When the stable counter reaches STABLE_CYC-1, latch period_in and amp_in in the same cycle and go to DIVIDE.
  - The timeout counter increments every cycle. On reaching TIMEOUT_CYC-1, go to PRESENT with freq_hz=0, amp_out=0, err=1. Partial accumulations are discarded.
  - If stable and timeout both fire in the same cycle, stable wins.
- DIVIDE: restoring unsigned divide, CLK_HZ / latched period, one quotient bit per cycle.
  - Exactly 32 cycles, then go to ACCUM. The quotient is truncated.
  - The divisor is guaranteed nonzero by the stable rule.
- ACCUM (1 cycle): freq_acc (32+AVG_LOG2 bits) += quotient; amp_acc (12+AVG_LOG2 bits) += latched amp; sample count += 1.
  - If count reaches 2^AVG_LOG2: freq_hz = freq_acc >> AVG_LOG2 and amp_out = amp_acc >> AVG_LOG2, both truncating; err=0; go to PRESENT.
  - Otherwise go to CLEAR.
- PRESENT: meas_valid=1. freq_hz, amp_out and err are held stable until meas_valid && meas_ready.
  - On that cycle: clear accumulators and count. Go to CLEAR if en=1, else IDLE.
  - meas_valid drops the cycle after acceptance.
  - Outputs keep their last values until the next result loads.
  - meas_ready high before valid has no effect.
- en low mid-run does not abort; it takes effect only at the PRESENT exit.
- Latency per sample: 1 (CLEAR) + analyzer measurement + STABLE_CYC + 32 + 1 cycles.

Decomposition:
- Package wave_meas_pkg holds:
  - state enum {IDLE, CLEAR, WAIT_STABLE, DIVIDE, ACCUM, PRESENT}
  - localparams PERIOD_W=32, AMP_W=12, DIV_STEPS=32
- Sub-module seq_divider_u32:
  - inputs: start, dividend, divisor
  - outputs: busy, done (1-cycle pulse), quotient
  - 32-cycle restoring algorithm; same clk/rst convention

Test Plan:
- AVG_LOG2=0, CLK_HZ=50e6. Period ramps, then freezes at 50000 with amp 800 -> capture after 1024 stable cycles. Divide takes 32 cycles, then meas_valid with freq_hz=1000, amp_out=800, err=0.
- AVG_LOG2=2. Frozen periods 50000, 50000, 25000, 25000 with amps 800, 800, 400, 402 -> freq_hz=1500, amp_out=600. Exactly four ana_clr pulses occur, one per sample.
- Period 3 (CLK_HZ=50e6) -> freq_hz=16666666 (truncation check).
- Hold meas_ready=0 for 100 cycles after valid -> outputs and meas_valid stay constant. One-cycle meas_ready -> valid drops the next cycle, and CLEAR follows if en=1.
- period_in stuck at 0, TIMEOUT_CYC=5000 -> PRESENT after 5000 cycles in WAIT_STABLE with freq_hz=0, amp_out=0, err=1.
- Assert rst during DIVIDE cycle 10 -> next cycle all outputs 0, FSM in IDLE, no meas_valid. With en=1 after release -> ana_clr pulse on the second cycle.
